arb5: RTL and testbench
=======================

# arb5

Five-requester round-robin arbiter generating the one-hot grant vector that steers the shared 32-bit, 5-input result mux onto the common bus. It holds a grant for the owner's whole tenure and forces rotation after a beat limit when other requesters are waiting. It also inserts a one-cycle dead gap on every handover so the mux never switches during a beat. Sits between the DMA channel engines, which drive `req`, and the shared bus slave, which drives `ack`.

## Interface
- `BEAT_LIMIT`, 16: acked beats per tenure before forced rotation under contention; legal range 1..255.
- `TIMEOUT`, 255: cycles without `ack` before forced release; legal range 1..255; used only with `ARB5_TIMEOUT_EN`.

- `wb_clk_i`  in  1  single clock; all state updates on the rising edge.
- `wb_rst_i`  in  1  reset, asynchronous, active-high.
- `req`  in  5  per-requester request; level, held for the whole tenure.
- `ack`  in  1  beat complete from the shared slave; counted only while a grant is active.
- `gnt`  out  5  registered grant, one-hot or zero; drives the mux select.
- `gnt_id`  out  3  encoded owner 0..4; 3'd7 when `gnt` is 0.
- `busy`  out  1  equals |`gnt`.
- `tmo`  out  1  one-cycle pulse on a timeout release.

## Operation
- Reset values: `gnt`=0, `gnt_id`=7, `busy`=0, `tmo`=0, state IDLE, last-owner pointer=4, beat counter=0, timeout counter=0.
- States:
  - IDLE: `gnt`=0. If any `req` bit is set, grant and go to OWN.
  - OWN: `gnt` is one-hot.
  - GAP: `gnt`=0 for exactly one cycle. If any `req` bit is set, grant and go to OWN; otherwise go to IDLE.
- Selection: search order is last+1, last+2, … last+5, modulo 5, with wrap 4→0. The first set `req` bit wins. On grant, last is set to the winner and both counters are cleared.
- OWN handling:
  - Each cycle with `ack`=1 increments the beat counter.
  - Release to GAP when `req[owner]`=0 is sampled.
  - Release to GAP when `ack`=1 and the count reaches `BEAT_LIMIT` and any other `req` bit is set.
  - If the limit is reached with no other requester, clear the beat counter and keep the grant.
- Simultaneous `ack` and owner `req` drop: the beat is counted, then the owner releases.
- The owner re-asserting `req` in GAP competes normally. It is lowest priority because it is now "last".
- `req` changes on non-owner lines during OWN have no effect on `gnt`.

## Timing
- Grant latency: `req` first sampled high at edge N gives `gnt` valid after edge N (visible in cycle N+1) when starting from IDLE.
- Handover: the releasing edge zeroes `gnt`. The next edge grants the new owner. Exactly one cycle of `gnt`=0 separates any two tenures.
- `gnt`, `gnt_id` and `busy` change together on the same edge, are registered, and are glitch-free.
- `tmo` is high for exactly the cycle following the timeout release edge.
- Asserting `wb_rst_i` mid-tenure clears all outputs immediately, with no clock edge required. After deassertion the first grant goes to the lowest-indexed requester, because last=4.

## Configuration
- `ARB5_TIMEOUT_EN` defined:
  - An 8-bit counter increments each OWN cycle with `ack`=0 and clears on `ack`.
  - When it reaches `TIMEOUT`, the owner is released to GAP and `tmo` pulses.
  - The timed-out owner is treated as last for rotation.
- `ARB5_TIMEOUT_EN` undefined:
  - No timeout counter is built.
  - `tmo` is tied to 0.
  - A stalled owner holds the grant indefinitely.

## Test plan
- Reset, then `req`=5'b00100 → next cycle `gnt`=5'b00100, `gnt_id`=2, `busy`=1. Drop `req` → `gnt`=0 one cycle later, then IDLE.
- `BEAT_LIMIT`=4, `req`=5'b11111 held, `ack`=1 every cycle → owners 0,1,2,3,4,0 in turn, each granted for 4 acked beats, with one `gnt`=0 cycle between tenures.
- Owner 3 active, `req`=5'b01010; drop `req[3]` → `gnt`=0 for 1 cycle, then 5'b00010.
- Wrap: last=4, then `req`=5'b10001 → `gnt`=5'b00001; same start with last=0 → `gnt`=5'b10000.
- `TIMEOUT`=8, `req[0]` held, `ack`=0:
  - Macro defined → `gnt` drops on the 8th stalled cycle, `tmo`=1 for one cycle.
  - Macro undefined → `gnt` stays 5'b00001 and `tmo`=0.
- Assert `wb_rst_i` mid-tenure between clock edges → `gnt`=0 and `gnt_id`=7 immediately. After release with `req`=5'b11000 → `gnt`=5'b01000.

Source files
------------

// File: rtl/arb5.sv
// arb5: five-requester round-robin arbiter with tenure hold, beat-limit
// rotation and a one-cycle dead gap on every handover.
// Optional feature macro: ARB5_TIMEOUT_EN (stalled-owner timeout release).
module arb5 #(
  parameter int unsigned BEAT_LIMIT = 16,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_i,
  input  logic [4:0] req,
  input  logic       ack,
  output logic [4:0] gnt,
  output logic [2:0] gnt_id,
  output logic       busy,
  output logic       tmo
);

  localparam int unsigned N_REQ = 5;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned ID_W  = 3;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_OWN  = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  localparam logic [ID_W-1:0]  ID_NONE  = 3'd7;
  localparam logic [ID_W-1:0]  LAST_RST = 3'd4;
  localparam logic [CNT_W-1:0] BEAT_LIM = CNT_W'(BEAT_LIMIT);

  // Elaboration-time range checks on the configuration.
  if (BEAT_LIMIT < 1 || BEAT_LIMIT > 255) begin : g_bad_beat_limit
    $error("arb5: BEAT_LIMIT must be in 1..255");
  end
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("arb5: TIMEOUT must be in 1..255");
  end

  logic [1:0]       state_q, state_d;
  logic [ID_W-1:0]  last_q, last_d;
  logic [CNT_W-1:0] beat_q, beat_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [ID_W-1:0]  gnt_id_q, gnt_id_d;
  logic             busy_q, busy_d;

  logic             pick_ok;
  logic [ID_W-1:0]  pick_id;
  logic             owner_req;
  logic             others_req;
  logic [CNT_W-1:0] beat_inc;
  logic             limit_hit;
  logic             release_c;

  // Round-robin search starting just after the last owner; the last owner
  // itself is examined last so it has the lowest priority.
  function automatic logic [ID_W:0] rr_pick(input logic [N_REQ-1:0] r,
                                            input logic [ID_W-1:0]  last);
    logic [ID_W:0] res;
    int unsigned   k;
    res = {1'b0, ID_NONE};
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      k = (32'(last) + i) % N_REQ;
      if (!res[ID_W] && r[k]) begin
        res = {1'b1, ID_W'(k)};
      end
    end
    return res;
  endfunction

  assign {pick_ok, pick_id} = rr_pick(req, last_q);

  // Owner and contention status derived from the registered grant.
  assign owner_req  = |(req & gnt_q);
  assign others_req = |(req & ~gnt_q);
  assign beat_inc   = beat_q + CNT_W'(1);
  assign limit_hit  = ack && (beat_inc == BEAT_LIM);

`ifdef ARB5_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TMO_LIM = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] tcnt_q, tcnt_d;
  logic             tmo_q, tmo_d;
  logic             tmo_hit;

  assign tmo_hit = !ack && ((tcnt_q + CNT_W'(1)) == TMO_LIM);
`endif

  // Next-state, counter and registered-output logic.
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    beat_d    = beat_q;
    gnt_d     = gnt_q;
    gnt_id_d  = gnt_id_q;
    busy_d    = busy_q;
    release_c = 1'b0;
`ifdef ARB5_TIMEOUT_EN
    tcnt_d    = tcnt_q;
    tmo_d     = 1'b0;
`endif

    case (state_q)
      ST_IDLE, ST_GAP: begin
        if (pick_ok) begin
          state_d  = ST_OWN;
          last_d   = pick_id;
          beat_d   = '0;
          gnt_d    = N_REQ'(5'b00001 << pick_id);
          gnt_id_d = pick_id;
          busy_d   = 1'b1;
`ifdef ARB5_TIMEOUT_EN
          tcnt_d   = '0;
`endif
        end else begin
          state_d  = ST_IDLE;
          gnt_d    = '0;
          gnt_id_d = ID_NONE;
          busy_d   = 1'b0;
        end
      end

      ST_OWN: begin
        if (ack) begin
          beat_d = beat_inc;
        end
        if (!owner_req) begin
          release_c = 1'b1;
        end else if (limit_hit && others_req) begin
          release_c = 1'b1;
        end else if (limit_hit) begin
          // Limit reached with nobody waiting: start a fresh tenure count.
          beat_d = '0;
        end
`ifdef ARB5_TIMEOUT_EN
        tcnt_d = ack ? '0 : (tcnt_q + CNT_W'(1));
        if (!release_c && tmo_hit) begin
          release_c = 1'b1;
          tmo_d     = 1'b1;
        end
`endif
        if (release_c) begin
          state_d  = ST_GAP;
          gnt_d    = '0;
          gnt_id_d = ID_NONE;
          busy_d   = 1'b0;
        end
      end

      default: begin
        state_d  = ST_IDLE;
        gnt_d    = '0;
        gnt_id_d = ID_NONE;
        busy_d   = 1'b0;
      end
    endcase
  end

  // State, pointer, counter and output registers.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q  <= ST_IDLE;
      last_q   <= LAST_RST;
      beat_q   <= '0;
      gnt_q    <= '0;
      gnt_id_q <= ID_NONE;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      beat_q   <= beat_d;
      gnt_q    <= gnt_d;
      gnt_id_q <= gnt_id_d;
      busy_q   <= busy_d;
    end
  end

`ifdef ARB5_TIMEOUT_EN
  // Stall counter and timeout pulse registers.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      tcnt_q <= '0;
      tmo_q  <= 1'b0;
    end else begin
      tcnt_q <= tcnt_d;
      tmo_q  <= tmo_d;
    end
  end

  assign tmo = tmo_q;
`else
  assign tmo = 1'b0;
`endif

  assign gnt    = gnt_q;
  assign gnt_id = gnt_id_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_arb5.sv
// tb_arb5: directed self-checking bench for arb5 (BEAT_LIMIT=4, TIMEOUT=8).
module tb_arb5;

  logic       clk;
  logic       rst;
  logic [4:0] req;
  logic       ack;
  logic [4:0] gnt;
  logic [2:0] gnt_id;
  logic       busy;
  logic       tmo;

  int n_tests;
  int n_fail;

  arb5 #(.BEAT_LIMIT(4), .TIMEOUT(8)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .req      (req),
    .ack      (ack),
    .gnt      (gnt),
    .gnt_id   (gnt_id),
    .busy     (busy),
    .tmo      (tmo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 5'b0;
    ack = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = 5'b0;
    ack = 1'b0;
    #2;
    n_tests++;
    if (gnt !== 5'b0) begin n_fail++; $display("FAIL reset_gnt: got %b want %b", gnt, 5'b0); end
    n_tests++;
    if (gnt_id !== 3'd7) begin n_fail++; $display("FAIL reset_id: got %0d want 7", gnt_id); end
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_tests++;
    if (tmo !== 1'b0) begin n_fail++; $display("FAIL reset_tmo: got %b want 0", tmo); end
    step();
    rst = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    req = 5'b00100;
    step();
    n_tests++;
    if (gnt !== 5'b00100 || gnt_id !== 3'd2 || busy !== 1'b1) begin
      n_fail++; $display("FAIL single_grant: got gnt=%b id=%0d busy=%b want 00100/2/1", gnt, gnt_id, busy);
    end
    req = 5'b0;
    step();
    n_tests++;
    if (gnt !== 5'b0 || gnt_id !== 3'd7 || busy !== 1'b0) begin
      n_fail++; $display("FAIL single_release: got gnt=%b id=%0d busy=%b want 00000/7/0", gnt, gnt_id, busy);
    end
    step();
    n_tests++;
    if (gnt !== 5'b0) begin n_fail++; $display("FAIL single_idle: got %b want 00000", gnt); end
  endtask

  task automatic test_beat_limit();
    int unsigned owners [6] = '{0, 1, 2, 3, 4, 0};
    logic [4:0] exp_g;
    do_reset();
    req = 5'b11111;
    ack = 1'b1;
    for (int t = 0; t < 6; t++) begin
      exp_g = 5'b00001 << owners[t];
      for (int k = 0; k < 4; k++) begin
        step();
        n_tests++;
        if (gnt !== exp_g || gnt_id !== 3'(owners[t])) begin
          n_fail++; $display("FAIL beat_tenure t%0d k%0d: got gnt=%b id=%0d want %b/%0d", t, k, gnt, gnt_id, exp_g, owners[t]);
        end
      end
      step();
      n_tests++;
      if (gnt !== 5'b0 || busy !== 1'b0) begin
        n_fail++; $display("FAIL beat_gap t%0d: got gnt=%b busy=%b want 00000/0", t, gnt, busy);
      end
    end
    req = 5'b0;
    ack = 1'b0;
    step();
  endtask

  task automatic test_limit_alone();
    do_reset();
    req = 5'b00010;
    ack = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      n_tests++;
      if (gnt !== 5'b00010) begin
        n_fail++; $display("FAIL limit_alone k%0d: got %b want 00010", k, gnt);
      end
    end
    req = 5'b0;
    ack = 1'b0;
    step();
    step();
  endtask

  task automatic test_release();
    do_reset();
    req = 5'b01000;
    step();
    n_tests++;
    if (gnt !== 5'b01000 || gnt_id !== 3'd3) begin
      n_fail++; $display("FAIL rel_own3: got gnt=%b id=%0d want 01000/3", gnt, gnt_id);
    end
    req = 5'b01010;
    step();
    n_tests++;
    if (gnt !== 5'b01000) begin n_fail++; $display("FAIL rel_hold: got %b want 01000", gnt); end
    req = 5'b00010;
    step();
    n_tests++;
    if (gnt !== 5'b0) begin n_fail++; $display("FAIL rel_gap: got %b want 00000", gnt); end
    step();
    n_tests++;
    if (gnt !== 5'b00010 || gnt_id !== 3'd1) begin
      n_fail++; $display("FAIL rel_next: got gnt=%b id=%0d want 00010/1", gnt, gnt_id);
    end
    req = 5'b0;
    step();
    step();
  endtask

  task automatic test_wrap();
    do_reset();
    req = 5'b10001;
    step();
    n_tests++;
    if (gnt !== 5'b00001) begin n_fail++; $display("FAIL wrap_last4: got %b want 00001", gnt); end
    req = 5'b0;
    step();
    step();
    req = 5'b10001;
    step();
    n_tests++;
    if (gnt !== 5'b10000 || gnt_id !== 3'd4) begin
      n_fail++; $display("FAIL wrap_last0: got gnt=%b id=%0d want 10000/4", gnt, gnt_id);
    end
    req = 5'b0;
    step();
    step();
  endtask

  task automatic test_timeout();
    do_reset();
    req = 5'b00001;
    ack = 1'b0;
    step();
`ifdef ARB5_TIMEOUT_EN
    for (int k = 1; k <= 7; k++) begin
      step();
      n_tests++;
      if (gnt !== 5'b00001 || tmo !== 1'b0) begin
        n_fail++; $display("FAIL tmo_hold k%0d: got gnt=%b tmo=%b want 00001/0", k, gnt, tmo);
      end
    end
    step();
    n_tests++;
    if (gnt !== 5'b0 || tmo !== 1'b1 || gnt_id !== 3'd7) begin
      n_fail++; $display("FAIL tmo_release: got gnt=%b tmo=%b id=%0d want 00000/1/7", gnt, tmo, gnt_id);
    end
    step();
    n_tests++;
    if (gnt !== 5'b00001 || tmo !== 1'b0) begin
      n_fail++; $display("FAIL tmo_regrant: got gnt=%b tmo=%b want 00001/0", gnt, tmo);
    end
`else
    for (int k = 1; k <= 12; k++) begin
      step();
      n_tests++;
      if (gnt !== 5'b00001 || tmo !== 1'b0) begin
        n_fail++; $display("FAIL stall_hold k%0d: got gnt=%b tmo=%b want 00001/0", k, gnt, tmo);
      end
    end
`endif
    req = 5'b0;
    step();
    step();
  endtask

  task automatic test_async_reset();
    do_reset();
    req = 5'b00100;
    step();
    n_tests++;
    if (gnt !== 5'b00100) begin n_fail++; $display("FAIL arst_pre: got %b want 00100", gnt); end
    #2;
    rst = 1'b1;
    #1;
    n_tests++;
    if (gnt !== 5'b0 || gnt_id !== 3'd7 || busy !== 1'b0) begin
      n_fail++; $display("FAIL arst_immediate: got gnt=%b id=%0d busy=%b want 00000/7/0", gnt, gnt_id, busy);
    end
    #1;
    req = 5'b11000;
    rst = 1'b0;
    step();
    n_tests++;
    if (gnt !== 5'b01000 || gnt_id !== 3'd3) begin
      n_fail++; $display("FAIL arst_first: got gnt=%b id=%0d want 01000/3", gnt, gnt_id);
    end
    req = 5'b0;
    step();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    req = 5'b0;
    ack = 1'b0;
    test_reset();
    test_single();
    test_beat_limit();
    test_limit_alone();
    test_release();
    test_wrap();
    test_timeout();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
